slime_hit_gen: RTL and testbench
================================

SLIME_HIT_GEN -- requirements
Module: slime_hit_gen

Interface
REQ-001 SHALL have parameter HITBOX_W, default 10'd16, meaning horizontal overlap threshold in pixels.
REQ-002 SHALL have parameter HITBOX_H, default 10'd16, meaning vertical overlap threshold in pixels.
REQ-003 SHALL have parameter TICK_DIV, default 6000000, meaning clk cycles per invulnerability tick (>=2).
REQ-004 SHALL have parameter IFRAME_TICKS, default 4'd15, meaning invulnerability length in ticks (>=1).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 game_run  input  1  1 = hits may be generated.
REQ-008 player_x, player_y  input  10 each  player sprite origin.
REQ-009 slime0_x, slime0_y, slime1_x, slime1_y  input  10 each  slime sprite origins.
REQ-010 slim_damage  output  2  registered one-cycle hit pulse; bit i = slime i; feeds the health counter.
REQ-011 invuln  output  1  registered; 1 while in COOLDOWN.
REQ-012 blink  output  1  registered sprite-flicker flag (see Configuration).

Function
REQ-013 Overlap_i SHALL be |player_x-slimei_x| < HITBOX_W AND |player_y-slimei_y| < HITBOX_H; absolute differences are computed unsigned 11-bit, no wrap-around.
REQ-014 The overlap vector SHALL be registered into overlap_q each cycle (pipeline stage 1).
REQ-015 FSM states SHALL be ARMED and COOLDOWN; reset state ARMED.
REQ-016 In ARMED with game_run=1 and overlap_q!=0: slim_damage <= overlap_q for exactly one cycle, state <= COOLDOWN, tick counter <= 0, iframe counter <= IFRAME_TICKS.
REQ-017 Input-to-pulse latency SHALL be 2 cycles: positions stable before edge k; pulse visible after edge k+1.
REQ-018 Both slimes overlapping in the same cycle SHALL produce slim_damage=2'b11 in a single pulse (one event).
REQ-019 In COOLDOWN, the tick counter SHALL count 0..TICK_DIV-1 and wrap; each wrap decrements the iframe counter.
REQ-020 When the iframe counter equals 1 and a tick wraps, state SHALL return to ARMED; COOLDOWN lasts exactly IFRAME_TICKS*TICK_DIV cycles.
REQ-021 In COOLDOWN, slim_damage SHALL be 0 regardless of overlap.
REQ-022 On return to ARMED with overlap_q still nonzero, a new pulse SHALL be emitted on the next cycle.
REQ-023 With game_run=0: slim_damage SHALL be 0, ARMED stays ARMED, COOLDOWN continues counting normally.
REQ-024 invuln SHALL be 1 exactly for the cycles the state is COOLDOWN.

Reset
REQ-025 reset=1 at a rising edge SHALL force state ARMED, overlap_q=0, both counters=0, slim_damage=0, invuln=0, blink=0; reset wins over any simultaneous hit.
REQ-026 Reset mid-COOLDOWN SHALL abort the cooldown; a hit one cycle after reset is released (after the 2-cycle pipeline refill) SHALL be accepted.

Configuration
REQ-027 Macro SLIME_HIT_BLINK_EN defined: blink SHALL toggle on every tick wrap during COOLDOWN, be set to 1 on entry to COOLDOWN, and be 0 in ARMED.
REQ-028 Macro SLIME_HIT_BLINK_EN undefined: blink SHALL be constant 0 and no toggle logic synthesized; all other behaviour identical.

Verification (TICK_DIV=4, IFRAME_TICKS=3, HITBOX 16x16)
REQ-029 Player (100,100), slime0 (110,105), game_run=1 -> slim_damage=2'b01 for one cycle, 2 cycles after stimulus; invuln=1 for 12 cycles.
REQ-030 Player (100,100), slime0 (116,100) -> no pulse (boundary, difference equal to HITBOX_W); slime0 (115,100) -> pulse.
REQ-031 Both slimes at (100,100) with player -> single pulse 2'b11; overlap held -> next pulse exactly 13 cycles after the first.
REQ-032 Reset asserted 5 cycles into COOLDOWN with overlap held -> invuln=0 immediately after reset; new pulse 2 cycles after reset deasserts.
REQ-033 game_run=0 with overlap held 20 cycles -> slim_damage stays 0; game_run raised -> pulse next cycle.
REQ-034 SLIME_HIT_BLINK_EN defined, hit taken -> blink sequence 1,0,1 at 4-cycle intervals, then 0 in ARMED; undefined -> blink always 0.

Source files
------------

// File: rtl/slime_hit_gen.sv
// rtl/slime_hit_gen.sv - player/slime overlap hit pulse with invulnerability cooldown
// Optional sprite flicker during cooldown is enabled by defining SLIME_HIT_BLINK_EN.
module slime_hit_gen #(
    parameter logic [9:0] HITBOX_W     = 10'd16,
    parameter logic [9:0] HITBOX_H     = 10'd16,
    parameter int         TICK_DIV     = 6000000,
    parameter logic [3:0] IFRAME_TICKS = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_run,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] slime0_x,
    input  logic [9:0] slime0_y,
    input  logic [9:0] slime1_x,
    input  logic [9:0] slime1_y,
    output logic [1:0] slim_damage,
    output logic       invuln,
    output logic       blink
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    overlap;
    logic [1:0]    overlap_q;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_next;
    logic [3:0]    iframe_cnt;
    logic [3:0]    iframe_next;
    logic [1:0]    damage_next;

    // Differences are widened to 11 bits so positions near 0/1023 never wrap.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    always_comb begin
        overlap[0] = (abs_diff(player_x, slime0_x) < {1'b0, HITBOX_W}) &&
                     (abs_diff(player_y, slime0_y) < {1'b0, HITBOX_H});
        overlap[1] = (abs_diff(player_x, slime1_x) < {1'b0, HITBOX_W}) &&
                     (abs_diff(player_y, slime1_y) < {1'b0, HITBOX_H});
    end

    always_comb begin
        state_next  = state;
        tick_next   = tick_cnt;
        iframe_next = iframe_cnt;
        damage_next = 2'b00;
        case (state)
            ARMED: begin
                if (game_run && (overlap_q != 2'b00)) begin
                    damage_next = overlap_q;
                    state_next  = COOLDOWN;
                    tick_next   = '0;
                    iframe_next = IFRAME_TICKS;
                end
            end
            COOLDOWN: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next   = '0;
                    iframe_next = iframe_cnt - 4'd1;
                    if (iframe_cnt == 4'd1) begin
                        state_next = ARMED;
                    end
                end else begin
                    tick_next = tick_cnt + TW'(1);
                end
            end
            default: state_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARMED;
            overlap_q   <= 2'b00;
            tick_cnt    <= '0;
            iframe_cnt  <= 4'd0;
            slim_damage <= 2'b00;
            invuln      <= 1'b0;
        end else begin
            state       <= state_next;
            overlap_q   <= overlap;
            tick_cnt    <= tick_next;
            iframe_cnt  <= iframe_next;
            slim_damage <= damage_next;
            invuln      <= (state_next == COOLDOWN);
        end
    end

`ifdef SLIME_HIT_BLINK_EN
    logic blink_q;
    logic blink_next;

    // Starts lit on the hit, flips each tick, and goes dark once re-armed.
    always_comb begin
        blink_next = 1'b0;
        if (state == ARMED) begin
            blink_next = (state_next == COOLDOWN);
        end else if (state_next == COOLDOWN) begin
            blink_next = (tick_cnt == TICK_LAST) ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_next;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_slime_hit_gen.sv
// tb/tb_slime_hit_gen.sv - scoreboard bench for slime_hit_gen (TICK_DIV=4, IFRAME_TICKS=3)
module tb_slime_hit_gen;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_run;
    logic [9:0] player_x, player_y;
    logic [9:0] slime0_x, slime0_y, slime1_x, slime1_y;
    logic [1:0] slim_damage;
    logic       invuln;
    logic       blink;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    pulse_t exp_q[$];
    pulse_t obs_q[$];

    slime_hit_gen #(
        .HITBOX_W    (10'd16),
        .HITBOX_H    (10'd16),
        .TICK_DIV    (4),
        .IFRAME_TICKS(4'd3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_run   (game_run),
        .player_x   (player_x),
        .player_y   (player_y),
        .slime0_x   (slime0_x),
        .slime0_y   (slime0_y),
        .slime1_x   (slime1_x),
        .slime1_y   (slime1_y),
        .slim_damage(slim_damage),
        .invuln     (invuln),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (slim_damage !== 2'b00) obs_q.push_back('{cyc, slim_damage});
    end

    task automatic place(input int px, input int py, input int s0x, input int s0y,
                         input int s1x, input int s1y);
        player_x = 10'(px);
        player_y = 10'(py);
        slime0_x = 10'(s0x);
        slime0_y = 10'(s0y);
        slime1_x = 10'(s1x);
        slime1_y = 10'(s1y);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        game_run = 1'b1;
        place(100, 100, 100, 100, 100, 100);
        wait_cycles(3);
        checks++;
        if (slim_damage !== 2'b00) begin
            errors++;
            $display("FAIL reset_damage: got %b want 00", slim_damage);
        end
        checks++;
        if (invuln !== 1'b0) begin
            errors++;
            $display("FAIL reset_invuln: got %b want 0", invuln);
        end
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL reset_blink: got %b want 0", blink);
        end
        place(100, 100, 500, 500, 500, 500);
        reset = 1'b0;
        wait_cycles(4);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_hit: got %0d pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_single_hit();
        int     n0;
        int     first;
        int     cnt;
        pulse_t e;
        pulse_t o;
        first = -1;
        cnt   = 0;
        place(100, 100, 110, 105, 500, 500);
        n0 = cyc;
        exp_q.push_back('{n0 + 2, 2'b01});
        wait_cycles(1);
        place(100, 100, 500, 500, 500, 500);
        for (int i = 0; i < 14; i++) begin
            wait_cycles(1);
            if (invuln === 1'b1) begin
                if (first < 0) first = cyc;
                cnt++;
            end
        end
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL single_invuln_len: got %0d want 12", cnt);
        end
        checks++;
        if (first != n0 + 2) begin
            errors++;
            $display("FAIL single_invuln_start: got %0d want %0d", first, n0 + 2);
        end
        wait_cycles(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL single_pulse: got none want %b at %0d", e.val, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    errors++;
                    $display("FAIL single_pulse: got %b at %0d want %b at %0d", o.val, o.cyc, e.val, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL single_extra: got %0d extra pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_boundary();
        int     tpx[9] = '{100, 100, 100, 100, 100, 100, 5, 1020, 0};
        int     tpy[9] = '{100, 100, 100, 100, 100, 100, 5, 1020, 0};
        int     tsx[9] = '{116, 115, 84, 85, 100, 100, 1020, 1005, 1023};
        int     tsy[9] = '{100, 100, 100, 100, 116, 115, 5, 1005, 1023};
        bit     hit[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        pulse_t e;
        pulse_t o;
        for (int i = 0; i < 9; i++) begin
            place(tpx[i], tpy[i], tsx[i], tsy[i], 500, 500);
            if (hit[i]) exp_q.push_back('{cyc + 2, 2'b01});
            wait_cycles(1);
            place(tpx[i], tpy[i], 500, 500, 500, 500);
            wait_cycles(14);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    errors++;
                    $display("FAIL boundary[%0d]: got no pulse want %b at %0d", i, e.val, e.cyc);
                end else begin
                    o = obs_q.pop_front();
                    if (o.cyc != e.cyc || o.val !== e.val) begin
                        errors++;
                        $display("FAIL boundary[%0d]: got %b at %0d want %b at %0d", i, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q.size() != 0) begin
                errors++;
                $display("FAIL boundary[%0d]_extra: got %0d pulses want 0", i, obs_q.size());
                obs_q.delete();
            end
        end
        place(100, 100, 500, 500, 500, 500);
    endtask

    task automatic test_both_hold();
        int     n0;
        pulse_t e;
        pulse_t o;
        place(100, 100, 100, 100, 100, 100);
        n0 = cyc;
        exp_q.push_back('{n0 + 2, 2'b11});
        exp_q.push_back('{n0 + 15, 2'b11});
        wait_cycles(16);
        place(100, 100, 500, 500, 500, 500);
        wait_cycles(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL both_pulse: got none want %b at %0d", e.val, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    errors++;
                    $display("FAIL both_pulse: got %b at %0d want %b at %0d", o.val, o.cyc, e.val, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL both_extra: got %0d extra pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_cooldown();
        int     n0;
        pulse_t e;
        pulse_t o;
        place(100, 100, 105, 100, 500, 500);
        n0 = cyc;
        exp_q.push_back('{n0 + 2, 2'b01});
        wait_cycles(7);
        checks++;
        if (invuln !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_invuln: got %b want 1", invuln);
        end
        reset = 1'b1;
        wait_cycles(1);
        checks++;
        if (invuln !== 1'b0) begin
            errors++;
            $display("FAIL midreset_invuln: got %b want 0", invuln);
        end
        reset = 1'b0;
        exp_q.push_back('{cyc + 2, 2'b01});
        wait_cycles(3);
        place(100, 100, 500, 500, 500, 500);
        wait_cycles(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL midreset_pulse: got none want %b at %0d", e.val, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    errors++;
                    $display("FAIL midreset_pulse: got %b at %0d want %b at %0d", o.val, o.cyc, e.val, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_extra: got %0d extra pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_game_run();
        int     inv_cnt;
        pulse_t e;
        pulse_t o;
        inv_cnt  = 0;
        game_run = 1'b0;
        place(100, 100, 100, 100, 500, 500);
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if (invuln !== 1'b0) inv_cnt++;
        end
        checks++;
        if (inv_cnt != 0) begin
            errors++;
            $display("FAIL gamerun_invuln: got %0d cycles want 0", inv_cnt);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL gamerun_idle: got %0d pulses want 0", obs_q.size());
            obs_q.delete();
        end
        game_run = 1'b1;
        exp_q.push_back('{cyc + 1, 2'b01});
        wait_cycles(1);
        place(100, 100, 500, 500, 500, 500);
        wait_cycles(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL gamerun_pulse: got none want %b at %0d", e.val, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    errors++;
                    $display("FAIL gamerun_pulse: got %b at %0d want %b at %0d", o.val, o.cyc, e.val, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL gamerun_extra: got %0d extra pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_blink();
        int     n0;
        int     off;
        logic   exp_b;
        pulse_t e;
        pulse_t o;
        place(100, 100, 100, 100, 500, 500);
        n0 = cyc;
        exp_q.push_back('{n0 + 2, 2'b01});
        wait_cycles(1);
        place(100, 100, 500, 500, 500, 500);
        for (int i = 0; i < 14; i++) begin
            wait_cycles(1);
            off   = cyc - (n0 + 2);
            exp_b = 1'b0;
`ifdef SLIME_HIT_BLINK_EN
            if (off >= 0 && off < 12) exp_b = ((off / 4) % 2 == 0);
`endif
            checks++;
            if (blink !== exp_b) begin
                errors++;
                $display("FAIL blink[%0d]: got %b want %b", off, blink, exp_b);
            end
        end
        wait_cycles(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL blink_pulse: got none want %b at %0d", e.val, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.val !== e.val) begin
                    errors++;
                    $display("FAIL blink_pulse: got %b at %0d want %b at %0d", o.val, o.cyc, e.val, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL blink_extra: got %0d extra pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        reset    = 1'b1;
        game_run = 1'b0;
        place(100, 100, 500, 500, 500, 500);
        test_reset();
        test_single_hit();
        test_boundary();
        test_both_hold();
        test_reset_mid_cooldown();
        test_game_run();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
